// File: rtl/matrix_uart_parser.sv
// matrix_uart_parser
//   Tokenizes an ASCII byte stream (from a UART receiver) into signed decimal
//   matrix elements. Tokens are separated by space/tab/CR; LF ends a line and
//   resets the column index. Malformed tokens raise a one-cycle parse_error
//   and the rest of the token is discarded up to the next separator.
//
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   rx_data       - received byte, examined only when rx_valid=1
//   rx_valid      - one-cycle strobe qualifying rx_data
//   clear         - synchronous abort: drop partial token, zero column index
//   num_valid     - one-cycle pulse: num_data/num_idx carry an accepted token
//   num_data      - signed element value, held until the next num_valid
//   num_idx       - 0-based column of num_data within the current line
//   line_end      - one-cycle pulse when an LF is consumed
//   parse_error   - one-cycle pulse on a malformed token
//   err_code      - 01 illegal char, 10 too many digits, 11 range/lone '-'
//
// All outputs are registered: they appear the cycle after the triggering byte.
module matrix_uart_parser #(
    parameter int ELEM_W     = 8,
    parameter int MAX_DIGITS = 3,
    parameter int ELEM_MIN   = -128,
    parameter int ELEM_MAX   = 127,
    parameter int IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              clear,
    output logic              num_valid,
    output logic [ELEM_W-1:0] num_data,
    output logic [IDX_W-1:0]  num_idx,
    output logic              line_end,
    output logic              parse_error,
    output logic [1:0]        err_code
);

    localparam int ACC_W = $clog2(10 ** MAX_DIGITS);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    // Two extra bits: one so the magnitude stays positive, one for the sign.
    localparam int VW    = ACC_W + 2;
    localparam logic signed [VW-1:0] MIN_V = VW'(ELEM_MIN);
    localparam logic signed [VW-1:0] MAX_V = VW'(ELEM_MAX);

    typedef enum logic [1:0] {IDLE, SIGN, DIGITS, DISCARD} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [IDX_W-1:0]  col_q, col_d;

    logic              num_valid_q, num_valid_d;
    logic [ELEM_W-1:0] num_data_q, num_data_d;
    logic [IDX_W-1:0]  num_idx_q, num_idx_d;
    logic              line_end_q, line_end_d;
    logic              parse_error_q, parse_error_d;
    logic [1:0]        err_code_q, err_code_d;

    // Byte classification
    logic       is_digit, is_minus, is_sep, is_eol;
    logic [3:0] digit;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_minus = (rx_data == 8'h2D);
    assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h09) || (rx_data == 8'h0D);
    assign is_eol   = (rx_data == 8'h0A);
    assign digit    = rx_data[3:0];

    // Signed value of the token currently held in the accumulator
    logic signed [VW-1:0] mag, tok_val;
    logic                 in_range;
    assign mag      = $signed({2'b00, acc_q});
    assign tok_val  = neg_q ? -mag : mag;
    assign in_range = (tok_val >= MIN_V) && (tok_val <= MAX_V);

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        neg_d         = neg_q;
        col_d         = col_q;
        num_valid_d   = 1'b0;
        num_data_d    = num_data_q;
        num_idx_d     = num_idx_q;
        line_end_d    = 1'b0;
        parse_error_d = 1'b0;
        err_code_d    = err_code_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b0;
            col_d   = '0;
        end else if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (is_eol) begin
                        line_end_d = 1'b1;
                        col_d      = '0;
                    end else if (is_digit) begin
                        acc_d   = ACC_W'(digit);
                        cnt_d   = CNT_W'(1);
                        neg_d   = 1'b0;
                        state_d = DIGITS;
                    end else if (is_minus) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        neg_d   = 1'b1;
                        state_d = SIGN;
                    end else if (!is_sep) begin
                        parse_error_d = 1'b1;
                        err_code_d    = 2'b01;
                        state_d       = DISCARD;
                    end
                end
                SIGN: begin
                    if (is_digit) begin
                        acc_d   = ACC_W'(digit);
                        cnt_d   = CNT_W'(1);
                        state_d = DIGITS;
                    end else if (is_sep || is_eol) begin
                        // Lone '-' is reported as a range violation
                        parse_error_d = 1'b1;
                        err_code_d    = 2'b11;
                        state_d       = IDLE;
                        if (is_eol) begin
                            line_end_d = 1'b1;
                            col_d      = '0;
                        end
                    end else begin
                        parse_error_d = 1'b1;
                        err_code_d    = 2'b01;
                        state_d       = DISCARD;
                    end
                end
                DIGITS: begin
                    if (is_digit) begin
                        if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                            acc_d = acc_q * ACC_W'(10) + ACC_W'(digit);
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            parse_error_d = 1'b1;
                            err_code_d    = 2'b10;
                            state_d       = DISCARD;
                        end
                    end else if (is_sep || is_eol) begin
                        if (in_range) begin
                            num_valid_d = 1'b1;
                            num_data_d  = tok_val[ELEM_W-1:0];
                            num_idx_d   = col_q;
                            if (col_q != '1)
                                col_d = col_q + IDX_W'(1);
                        end else begin
                            parse_error_d = 1'b1;
                            err_code_d    = 2'b11;
                        end
                        state_d = IDLE;
                        // num_idx above already captured the pre-reset column
                        if (is_eol) begin
                            line_end_d = 1'b1;
                            col_d      = '0;
                        end
                    end else begin
                        parse_error_d = 1'b1;
                        err_code_d    = 2'b01;
                        state_d       = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_sep) begin
                        state_d = IDLE;
                    end else if (is_eol) begin
                        line_end_d = 1'b1;
                        col_d      = '0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            neg_q         <= 1'b0;
            col_q         <= '0;
            num_valid_q   <= 1'b0;
            num_data_q    <= '0;
            num_idx_q     <= '0;
            line_end_q    <= 1'b0;
            parse_error_q <= 1'b0;
            err_code_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            neg_q         <= neg_d;
            col_q         <= col_d;
            num_valid_q   <= num_valid_d;
            num_data_q    <= num_data_d;
            num_idx_q     <= num_idx_d;
            line_end_q    <= line_end_d;
            parse_error_q <= parse_error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign num_valid   = num_valid_q;
    assign num_data    = num_data_q;
    assign num_idx     = num_idx_q;
    assign line_end    = line_end_q;
    assign parse_error = parse_error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_matrix_uart_parser.sv
// Self-checking bench for matrix_uart_parser: directed strings from the test
// plan followed by randomized byte streams, all compared cycle by cycle
// against a token-text reference model.
module tb_matrix_uart_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clear;
    logic       num_valid;
    logic [7:0] num_data;
    logic [3:0] num_idx;
    logic       line_end;
    logic       parse_error;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_uart_parser dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .clear      (clear),
        .num_valid  (num_valid),
        .num_data   (num_data),
        .num_idx    (num_idx),
        .line_end   (line_end),
        .parse_error(parse_error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (works on token text) ----------------
    byte tok[$];
    bit  bad;
    int  col;
    int  e_nv, e_data, e_idx, e_le, e_pe, e_code;

    function automatic void model_reset();
        tok.delete(); bad = 0; col = 0;
        e_nv = 0; e_data = 0; e_idx = 0; e_le = 0; e_pe = 0; e_code = 0;
    endfunction

    function automatic void model_clear();
        tok.delete(); bad = 0; col = 0;
        e_nv = 0; e_le = 0; e_pe = 0;
    endfunction

    function automatic void model_err(input int code);
        e_pe = 1; e_code = code; bad = 1; tok.delete();
    endfunction

    function automatic void model_byte(input byte b);
        bit dig, sep, eol;
        int v, ndig;
        bit neg;
        e_nv = 0; e_le = 0; e_pe = 0;
        dig = (b >= 8'h30 && b <= 8'h39);
        sep = (b == 8'h20 || b == 8'h09 || b == 8'h0D);
        eol = (b == 8'h0A);
        ndig = 0;
        foreach (tok[i]) if (tok[i] != 8'h2D) ndig++;
        if (bad) begin
            if (sep || eol) bad = 0;
        end else if (sep || eol) begin
            if (tok.size() != 0) begin
                v = 0; neg = 0;
                foreach (tok[i]) begin
                    if (tok[i] == 8'h2D) neg = 1;
                    else v = v * 10 + (int'(tok[i]) - 48);
                end
                if (neg) v = -v;
                if (ndig == 0 || v < -128 || v > 127) begin
                    e_pe = 1; e_code = 3;
                end else begin
                    e_nv = 1; e_data = v; e_idx = col;
                    if (col < 15) col++;
                end
                tok.delete();
            end
        end else if (dig) begin
            if (ndig >= 3) model_err(2);
            else tok.push_back(b);
        end else if (b == 8'h2D && tok.size() == 0) begin
            tok.push_back(b);
        end else begin
            model_err(1);
        end
        if (eol) begin
            e_le = 1; col = 0;
        end
    endfunction

    task automatic compare_outputs(input string where);
        check_eq({where, " num_valid"},   int'(num_valid),   e_nv);
        check_eq({where, " num_data"},    int'($signed(num_data)), e_data);
        check_eq({where, " num_idx"},     int'(num_idx),     e_idx);
        check_eq({where, " line_end"},    int'(line_end),    e_le);
        check_eq({where, " parse_error"}, int'(parse_error), e_pe);
        check_eq({where, " err_code"},    int'(err_code),    e_code);
    endtask

    // One clock cycle of stimulus; outputs are checked 1 ns after the edge.
    task automatic step(input logic v, input logic [7:0] b, input logic c);
        rx_valid = v; rx_data = b; clear = c;
        @(posedge clk); #1;
        if (c) model_clear();
        else if (v) model_byte(b);
        else begin e_nv = 0; e_le = 0; e_pe = 0; end
        compare_outputs($sformatf("byte=%02h v=%0d clr=%0d", b, v, c));
        if (v || c)
            $display("txn byte=%02h valid=%0d clear=%0d -> nv=%0d data=%0d idx=%0d le=%0d pe=%0d code=%0d",
                     b, v, c, num_valid, $signed(num_data), num_idx, line_end, parse_error, err_code);
        rx_valid = 0; clear = 0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 13);
        case (r)
            0, 1, 2, 3, 4, 5: return 8'(8'h30 + $urandom_range(0, 9));
            6, 7:  return 8'h20;
            8:     return 8'h2D;
            9:     return 8'h0A;
            10:    return 8'h09;
            11:    return 8'h0D;
            12:    return 8'h61;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        rst = 1; rx_valid = 0; rx_data = 0; clear = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs("reset");
        rst = 0;
        step(1'b0, 8'h00, 1'b0);

        send_str("12 -7 0\n");
        send_str("127 -128 128\n");
        send_str("1234 5\n");
        send_str("3a4 - 9\n");
        send_str("\n\r\n  \n");

        // clear in the same cycle as the byte after "45"
        send_str("45");
        step(1'b1, 8'h20, 1'b1);
        send_str("6\n");

        // column index saturation
        send_str("1 2 3 4 5 6 7 8 9 10 11 12 13 14 15 16 17 18\n");

        // asynchronous reset in the middle of "-8"
        send_str("-8");
        #2 rst = 1;
        #1;
        model_reset();
        compare_outputs("async rst");
        @(posedge clk); #1;
        rst = 0;
        compare_outputs("in rst");
        send_str(" \n");

        // randomized streams with idle gaps and occasional clear
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0)
                step($urandom_range(0, 1) == 1, rand_byte(), 1'b1);
            else if ($urandom_range(0, 4) == 0)
                step(1'b0, rand_byte(), 1'b0);
            else
                step(1'b1, rand_byte(), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
